comm_master: RTL and testbench



---
 rtl/comm_master.sv | 164 ++++++++++++++++
 tb/tb_comm_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/comm_master.sv
// Host-side UART command master: sends a 16-bit command as two 8N1 bytes (high first) and receives 8N1 response bytes.
// Optional COMM_MASTER_CLR_ON_SEND_EN: accepting a new command also clears a stale resp_cmplt.
module comm_master #(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_cmplt,
    output logic [7:0]  resp,
    output logic        resp_cmplt,
    input  logic        clr_rdy
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, SEND_HI, SEND_LO} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t   tx_state;
    logic [11:0] tx_cnt;
    logic [3:0]  tx_bits;
    logic [9:0]  tx_shift;
    logic [7:0]  cmd_lo;
    logic        tx_accept;
    logic        tx_tick;

    rx_state_t   rx_state;
    logic [11:0] rx_cnt;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_shift;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic        rx_tick;
    logic        send_clear;

    assign tx_accept = snd_cmd && (tx_state == TX_IDLE);
    assign tx_tick   = (tx_cnt == BAUD_LAST);
    assign rx_tick   = (rx_cnt == BAUD_LAST);

`ifdef COMM_MASTER_CLR_ON_SEND_EN
    assign send_clear = tx_accept;
`else
    assign send_clear = 1'b0;
`endif

    // Counter is preloaded to the last count so the start bit appears one edge after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bits   <= '0;
            tx_shift  <= '1;
            cmd_lo    <= '0;
            TX        <= 1'b1;
            cmd_cmplt <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_shift  <= {1'b1, cmd[15:8], 1'b0};
                        cmd_lo    <= cmd[7:0];
                        tx_cnt    <= BAUD_LAST;
                        tx_bits   <= '0;
                        cmd_cmplt <= 1'b0;
                        tx_state  <= SEND_HI;
                    end
                end
                SEND_HI, SEND_LO: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bits == 4'd10) begin
                            if (tx_state == SEND_HI) begin
                                TX       <= 1'b0;
                                tx_shift <= {2'b11, cmd_lo};
                                tx_bits  <= 4'd1;
                                tx_state <= SEND_LO;
                            end else begin
                                cmd_cmplt <= 1'b1;
                                tx_state  <= TX_IDLE;
                            end
                        end else begin
                            TX       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[9:1]};
                            tx_bits  <= tx_bits + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 12'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Clears are applied first so a completing byte on the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bits    <= '0;
            rx_shift   <= '0;
            resp       <= '0;
            resp_cmplt <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (clr_rdy || send_clear)
                resp_cmplt <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt     <= '0;
                        resp_cmplt <= 1'b0;
                        rx_state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            resp       <= rx_shift;
                            resp_cmplt <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master: directed and randomized transmit/receive checked against a frame-level model.
module tb_comm_master;

    localparam int B = 16;
    localparam int H = B / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_cmplt;
    logic [7:0]  resp;
    logic        resp_cmplt;
    logic        clr_rdy;
    logic        rx_drv;
    logic        loopback;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] exp_resp;
    logic       exp_rdy;

    int         cmplt_rises = 0;
    int         rdy_rises = 0;
    logic       cmplt_q = 1'b0;
    logic       rdy_q = 1'b0;
    logic [7:0] rise_log[$];

    assign RX = loopback ? TX : rx_drv;

    comm_master #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .snd_cmd    (snd_cmd),
        .cmd_cmplt  (cmd_cmplt),
        .resp       (resp),
        .resp_cmplt (resp_cmplt),
        .clr_rdy    (clr_rdy)
    );

    always #5 clk = ~clk;

    // Rising-edge bookkeeping for the completion flags, sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_cmplt && !cmplt_q)
            cmplt_rises++;
        if (resp_cmplt && !rdy_q) begin
            rdy_rises++;
            rise_log.push_back(resp);
        end
        cmplt_q = cmd_cmplt;
        rdy_q   = resp_cmplt;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one command and checks every bit at mid-bit plus the completion timing.
    task automatic applyStimulus(input logic [15:0] c, input bit busy);
        logic [19:0] frame;
        int          rises0;
        frame  = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
        rises0 = cmplt_rises;
        cmd     = c;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd     = 16'($urandom);
`ifdef COMM_MASTER_CLR_ON_SEND_EN
        exp_rdy = 1'b0;
`endif
        checkOutput("cmplt_clear", 16'(cmd_cmplt), 16'd0);
        for (int t = 1; t <= 20 * B + 1; t++) begin
            if (busy && t == 40) begin
                cmd     = 16'h1234;
                snd_cmd = 1'b1;
            end
            if (busy && t == 41)
                snd_cmd = 1'b0;
            @(negedge clk);
            if ((t - 1) % B == H && (t - 1) / B < 20)
                checkOutput($sformatf("tx_bit%0d", (t - 1) / B), 16'(TX), 16'(frame[(t - 1) / B]));
            if (t == 20 * B)
                checkOutput("cmplt_early", 16'(cmd_cmplt), 16'd0);
        end
        checkOutput("cmplt_set", 16'(cmd_cmplt), 16'd1);
        tick(30);
        checkOutput("tx_idle", 16'(TX), 16'd1);
        checkOutput("cmplt_rises", 16'(cmplt_rises - rises0), 16'd1);
    endtask

    task automatic driveRxFrame(input logic [7:0] d, input logic stop_bit, input bit check_lat);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int m = 0; m < 10 * B; m++) begin
            rx_drv = f[m / B];
            @(negedge clk);
            if (check_lat && m + 1 == H + 9 * B + 1)
                checkOutput("rx_lat_early", 16'(resp_cmplt), 16'd0);
            if (check_lat && m + 1 == H + 9 * B + 4)
                checkOutput("rx_lat_late", 16'(resp_cmplt), 16'd1);
        end
        rx_drv  = 1'b1;
        exp_rdy = 1'b0;
        if (stop_bit) begin
            exp_resp = d;
            exp_rdy  = 1'b1;
        end
        tick(4);
        checkOutput("resp", 16'(resp), 16'(exp_resp));
        checkOutput("resp_cmplt", 16'(resp_cmplt), 16'(exp_rdy));
    endtask

    task automatic pulseClr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        exp_rdy = 1'b0;
        checkOutput("clr_rdy", 16'(resp_cmplt), 16'(exp_rdy));
        checkOutput("clr_resp_kept", 16'(resp), 16'(exp_resp));
    endtask

    initial begin
        int         rises0;
        logic [7:0] d;
        rst      = 1'b1;
        snd_cmd  = 1'b0;
        clr_rdy  = 1'b0;
        cmd      = 16'h0000;
        rx_drv   = 1'b0;
        loopback = 1'b0;
        exp_resp = 8'h00;
        exp_rdy  = 1'b0;

        for (int i = 0; i < 6; i++) begin
            snd_cmd = ~snd_cmd;
            @(negedge clk);
        end
        checkOutput("rst_tx", 16'(TX), 16'd1);
        checkOutput("rst_cmplt", 16'(cmd_cmplt), 16'd0);
        checkOutput("rst_rdy", 16'(resp_cmplt), 16'd0);
        checkOutput("rst_resp", 16'(resp), 16'h00);
        snd_cmd = 1'b0;
        rx_drv  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);

        applyStimulus(16'hA55A, 1'b0);
        applyStimulus(16'hA55A, 1'b1);
        for (int i = 0; i < 2; i++)
            applyStimulus(16'($urandom), 1'b0);

        driveRxFrame(8'h3C, 1'b1, 1'b1);
        pulseClr();

        rx_drv = 1'b0;
        tick(5);
        rx_drv = 1'b1;
        tick(40);
        exp_rdy = 1'b0;
        checkOutput("glitch_resp", 16'(resp), 16'(exp_resp));
        checkOutput("glitch_rdy", 16'(resp_cmplt), 16'(exp_rdy));

        driveRxFrame(8'h81, 1'b0, 1'b0);
        tick(10);

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            driveRxFrame(d, ($urandom_range(0, 3) != 0), 1'b0);
            tick($urandom_range(2, 20));
            if ($urandom_range(0, 1) == 1)
                pulseClr();
        end

        loopback = 1'b1;
        rise_log.delete();
        rises0 = rdy_rises;
        applyStimulus(16'hC3E7, 1'b0);
        exp_resp = 8'hE7;
        exp_rdy  = 1'b1;
        checkOutput("loop_events", 16'(rdy_rises - rises0), 16'd2);
        checkOutput("loop_first", 16'(rise_log.size() > 0 ? rise_log[0] : 8'hxx), 16'h00C3);
        checkOutput("loop_resp", 16'(resp), 16'(exp_resp));
        checkOutput("loop_rdy", 16'(resp_cmplt), 16'(exp_rdy));

        cmd     = 16'($urandom);
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        tick(50);
        rst = 1'b1;
        @(negedge clk);
        exp_resp = 8'h00;
        exp_rdy  = 1'b0;
        checkOutput("midrst_tx", 16'(TX), 16'd1);
        checkOutput("midrst_cmplt", 16'(cmd_cmplt), 16'd0);
        checkOutput("midrst_resp", 16'(resp), 16'(exp_resp));
        checkOutput("midrst_rdy", 16'(resp_cmplt), 16'(exp_rdy));
        tick(2);
        loopback = 1'b0;
        rx_drv   = 1'b1;
        rst      = 1'b0;
        tick(5);
        driveRxFrame(8'($urandom), 1'b1, 1'b1);
        applyStimulus(16'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
